// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding and frame constants.
package uart_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int FRAME_LEN      = DATA_W_DEFAULT + 3;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_holdreg.sv
// Valid/ready holding register for one received frame. A frame arriving while
// the register is still occupied (and not being drained) is dropped and a
// one-cycle overrun pulse is raised.
module uart_rx_holdreg #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         ready,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         overrun
);

  logic         valid_q, valid_d;
  logic [W-1:0] dout_q, dout_d;
  logic         overrun_q, overrun_d;

  // Accept, drop or drain the held frame based on load/ready.
  always_comb begin
    valid_d   = valid_q;
    dout_d    = dout_q;
    overrun_d = 1'b0;
    if (load) begin
      if (!valid_q || ready) begin
        valid_d = 1'b1;
        dout_d  = din;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state; rst is active-low and asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      dout_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      dout_q    <= dout_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid   = valid_q;
  assign dout    = dout_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/uart_rx_checker.sv
// UART receive checker: one bit per clk, start + DATA_W data (LSB first) +
// even parity + stop. Delivers byte and parity/framing flags through a
// valid/ready holding register.
// Optional build macro UART_RX_ERRCNT_EN adds saturating parity/framing
// error counters with a synchronous clear input.
module uart_rx_checker
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              rx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_perr,
  output logic              rx_ferr,
`ifdef UART_RX_ERRCNT_EN
  input  logic              cnt_clr,
  output logic [7:0]        perr_cnt,
  output logic [7:0]        ferr_cnt,
`endif
  output logic              rx_overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic              armed_q, armed_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              commit;
  logic              ferr_n;
  logic [DATA_W+1:0] hold_dout;

  // Frame sequencer: start detect, data shift, parity and stop checks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    armed_d = armed_q;
    perr_d  = perr_q;
    shreg_d = shreg_q;
    commit  = 1'b0;
    ferr_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && rx_in == START_BIT) begin
          state_d = DATA;
          cnt_d   = '0;
          acc_d   = 1'b0;
        end else if (rx_in) begin
          armed_d = 1'b1;
        end
      end
      DATA: begin
        shreg_d = {rx_in, shreg_q[DATA_W-1:1]};
        acc_d   = acc_q ^ rx_in;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) state_d = PARITY;
      end
      PARITY: begin
        perr_d  = acc_q ^ rx_in;
        state_d = STOP;
      end
      STOP: begin
        ferr_n  = (rx_in != STOP_BIT);
        commit  = 1'b1;
        state_d = IDLE;
        // A low stop bit means a break: wait for the line to go high again.
        if (ferr_n) armed_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state of the sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      armed_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      armed_q <= armed_d;
      perr_q  <= perr_d;
    end
  end

  // Data shift register; contents are only meaningful once a frame completes.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  uart_rx_holdreg #(
    .W(DATA_W + 2)
  ) u_holdreg (
    .clk     (clk),
    .rst     (rst),
    .load    (commit),
    .ready   (rx_ready),
    .din     ({ferr_n, perr_q, shreg_q}),
    .valid   (rx_valid),
    .dout    (hold_dout),
    .overrun (rx_overrun)
  );

  assign rx_data = hold_dout[DATA_W-1:0];
  assign rx_perr = hold_dout[DATA_W];
  assign rx_ferr = hold_dout[DATA_W+1];

`ifdef UART_RX_ERRCNT_EN
  logic [7:0] perr_cnt_q, perr_cnt_d;
  logic [7:0] ferr_cnt_q, ferr_cnt_d;

  // Saturating error counters; counted at commit, including dropped frames.
  always_comb begin
    perr_cnt_d = perr_cnt_q;
    ferr_cnt_d = ferr_cnt_q;
    if (cnt_clr) begin
      perr_cnt_d = '0;
      ferr_cnt_d = '0;
    end else if (commit) begin
      if (perr_q && perr_cnt_q != 8'hFF) perr_cnt_d = perr_cnt_q + 8'd1;
      if (ferr_n && ferr_cnt_q != 8'hFF) ferr_cnt_d = ferr_cnt_q + 8'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr_cnt_q <= '0;
      ferr_cnt_q <= '0;
    end else begin
      perr_cnt_q <= perr_cnt_d;
      ferr_cnt_q <= ferr_cnt_d;
    end
  end

  assign perr_cnt = perr_cnt_q;
  assign ferr_cnt = ferr_cnt_q;
`endif

endmodule
